// File: rtl/bomber_pkg.sv
// Shared scancodes, decoder state, key-state struct and play-area geometry
// for the two-player sprite movement slice.
package bomber_pkg;

    localparam int HACTIVE = 800;
    localparam int VACTIVE = 600;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic bomb;
    } keys_t;

    typedef enum logic [2:0] {K_NONE, K_UP, K_DOWN, K_LEFT, K_RIGHT, K_BOMB} key_id_t;

    typedef struct packed {
        logic    player;
        key_id_t key;
    } key_hit_t;

    // Arrow keys only count with the E0 prefix; everything else only without it.
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t h;
        h.player = 1'b0;
        h.key    = K_NONE;
        if (!ext) begin
            case (code)
                SC_W:     h.key = K_UP;
                SC_S:     h.key = K_DOWN;
                SC_A:     h.key = K_LEFT;
                SC_D:     h.key = K_RIGHT;
                SC_SPACE: h.key = K_BOMB;
                SC_ENTER: begin h.player = 1'b1; h.key = K_BOMB; end
                default:  h.key = K_NONE;
            endcase
        end else begin
            h.player = 1'b1;
            case (code)
                SC_UP:    h.key = K_UP;
                SC_DOWN:  h.key = K_DOWN;
                SC_LEFT:  h.key = K_LEFT;
                SC_RIGHT: h.key = K_RIGHT;
                default:  h.key = K_NONE;
            endcase
        end
        return h;
    endfunction

    function automatic keys_t set_key(input keys_t k, input key_id_t id, input logic v);
        keys_t r;
        r = k;
        case (id)
            K_UP:    r.up    = v;
            K_DOWN:  r.down  = v;
            K_LEFT:  r.left  = v;
            K_RIGHT: r.right = v;
            K_BOMB:  r.bomb  = v;
            default: r = k;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/player_move_sched_if.sv
// Keyboard byte stream from the PS/2 receiver.
interface player_move_sched_if;
    logic [7:0] data_out;
    logic       data_valid;

    modport master (output data_out, output data_valid);
    modport slave  (input  data_out, input  data_valid);
endinterface

// File: rtl/ps2_key_decoder.sv
// Set-2 scancode decoder: tracks E0/F0 prefixes and holds per-player key state,
// flagging the press edge of each bomb key.
module ps2_key_decoder
    import bomber_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_out,
    input  logic       data_valid,
    output keys_t      p1_keys,
    output keys_t      p2_keys,
    output logic       p1_bomb_press,
    output logic       p2_bomb_press
);

    dec_state_t state, state_nx;
    keys_t      p1_nx, p2_nx;
    key_hit_t   hit;
    logic       do_set, do_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            p1_keys <= '0;
            p2_keys <= '0;
        end else begin
            state   <= state_nx;
            p1_keys <= p1_nx;
            p2_keys <= p2_nx;
        end
    end

    always_comb begin
        state_nx = state;
        do_set   = 1'b0;
        do_clr   = 1'b0;
        hit      = key_lookup(data_out, (state == EXT) || (state == EXT_BRK));
        if (data_valid) begin
            case (state)
                IDLE: begin
                    if (data_out == SC_E0)      state_nx = EXT;
                    else if (data_out == SC_F0) state_nx = BRK;
                    else                        do_set   = 1'b1;
                end
                EXT: begin
                    if (data_out == SC_F0) begin
                        state_nx = EXT_BRK;
                    end else begin
                        do_set   = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    do_clr   = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        p1_nx         = p1_keys;
        p2_nx         = p2_keys;
        p1_bomb_press = 1'b0;
        p2_bomb_press = 1'b0;
        if ((do_set || do_clr) && hit.key != K_NONE) begin
            if (!hit.player) begin
                p1_bomb_press = do_set && (hit.key == K_BOMB) && !p1_keys.bomb;
                p1_nx         = set_key(p1_keys, hit.key, do_set);
            end else begin
                p2_bomb_press = do_set && (hit.key == K_BOMB) && !p2_keys.bomb;
                p2_nx         = set_key(p2_keys, hit.key, do_set);
            end
        end
    end

endmodule

// File: rtl/player_move_sched.sv
// Per-frame movement of two player sprites with clamping, priority-based
// collision arbitration and one-shot bomb requests, all committed on EOF.
module player_move_sched
    import bomber_pkg::keys_t;
#(
    parameter int HACTIVE = bomber_pkg::HACTIVE,
    parameter int VACTIVE = bomber_pkg::VACTIVE,
    parameter int SIZE    = 32,
    parameter int STEP    = 2,
    parameter int P1_X0   = 100,
    parameter int P1_Y0   = 100,
    parameter int P2_X0   = 668,
    parameter int P2_Y0   = 468
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                EOF,
    player_move_sched_if.slave  kbd,
    output logic signed [10:0]  p1X,
    output logic signed [10:0]  p1Y,
    output logic signed [10:0]  p2X,
    output logic signed [10:0]  p2Y,
    output logic                p1_bomb,
    output logic                p2_bomb,
    output logic                prio
);

    keys_t p1_keys, p2_keys;
    logic  p1_bomb_press, p2_bomb_press;
    logic  p1_pend, p2_pend;

    ps2_key_decoder u_dec (
        .clk           (clk),
        .reset         (reset),
        .data_out      (kbd.data_out),
        .data_valid    (kbd.data_valid),
        .p1_keys       (p1_keys),
        .p2_keys       (p2_keys),
        .p1_bomb_press (p1_bomb_press),
        .p2_bomb_press (p2_bomb_press)
    );

    function automatic logic signed [10:0] step_axis(input logic signed [10:0] pos,
                                                     input logic inc, input logic dec,
                                                     input int lim);
        int c;
        c = int'(pos);
        if (inc && !dec)      c = c + STEP;
        else if (dec && !inc) c = c - STEP;
        if (c < 0)            c = 0;
        else if (c > lim)     c = lim;
        return c[10:0];
    endfunction

    function automatic logic overlaps(input logic signed [10:0] ax, input logic signed [10:0] ay,
                                      input logic signed [10:0] bx, input logic signed [10:0] by);
        int dx, dy;
        dx = int'(ax) - int'(bx);
        dy = int'(ay) - int'(by);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx < SIZE) && (dy < SIZE);
    endfunction

    logic signed [10:0] c1x, c1y, c2x, c2y;
    logic signed [10:0] r1x, r1y, r2x, r2y;

    // The priority player resolves against the other's old position; the other
    // then resolves against the priority player's new position.
    always_comb begin
        c1x = step_axis(p1X, p1_keys.right, p1_keys.left, HACTIVE - SIZE);
        c1y = step_axis(p1Y, p1_keys.down,  p1_keys.up,   VACTIVE - SIZE);
        c2x = step_axis(p2X, p2_keys.right, p2_keys.left, HACTIVE - SIZE);
        c2y = step_axis(p2Y, p2_keys.down,  p2_keys.up,   VACTIVE - SIZE);
        r1x = p1X;
        r1y = p1Y;
        r2x = p2X;
        r2y = p2Y;
        if (!prio) begin
            if (!overlaps(c1x, c1y, p2X, p2Y)) begin r1x = c1x; r1y = c1y; end
            if (!overlaps(c2x, c2y, r1x, r1y)) begin r2x = c2x; r2y = c2y; end
        end else begin
            if (!overlaps(c2x, c2y, p1X, p1Y)) begin r2x = c2x; r2y = c2y; end
            if (!overlaps(c1x, c1y, r2x, r2y)) begin r1x = c1x; r1y = c1y; end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1X     <= 11'(P1_X0);
            p1Y     <= 11'(P1_Y0);
            p2X     <= 11'(P2_X0);
            p2Y     <= 11'(P2_Y0);
            p1_bomb <= 1'b0;
            p2_bomb <= 1'b0;
            p1_pend <= 1'b0;
            p2_pend <= 1'b0;
            prio    <= 1'b0;
        end else begin
            // A press landing on the EOF cycle belongs to the next frame.
            p1_pend <= (p1_pend & ~EOF) | p1_bomb_press;
            p2_pend <= (p2_pend & ~EOF) | p2_bomb_press;
            p1_bomb <= EOF & p1_pend;
            p2_bomb <= EOF & p2_pend;
            if (EOF) begin
                p1X  <= r1x;
                p1Y  <= r1y;
                p2X  <= r2x;
                p2Y  <= r2y;
                prio <= ~prio;
            end
        end
    end

endmodule
